// File: rtl/window_updater.sv
// window_updater: frame-synchronous crop-window source.
// Software writes land in shadow registers. At the next frame start the
// pending window is clamped to the current image size over two cycles and
// published on m_*, so downstream consumers only see a window change
// between frames.
//
// Handshake: s_wr_en is a one-cycle write strobe with no ready; every
// strobe is accepted on the edge it is sampled, and the last write before a
// frame start wins. fsync is a one-cycle pulse; it only starts a publish when
// the FSM is idle and a window is pending, otherwise it is dropped.
// m_update is a one-cycle valid pulse with no backpressure.
module window_updater #(
   parameter int C_HBITS = 12,
   parameter int C_WBITS = 12
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               s_wr_en,
   input  logic [C_WBITS-1:0] s_left,
   input  logic [C_WBITS-1:0] s_width,
   input  logic [C_HBITS-1:0] s_top,
   input  logic [C_HBITS-1:0] s_height,
   input  logic [C_WBITS-1:0] img_width,
   input  logic [C_HBITS-1:0] img_height,
   input  logic               fsync,
   output logic [C_WBITS-1:0] m_left,
   output logic [C_WBITS-1:0] m_width,
   output logic [C_HBITS-1:0] m_top,
   output logic [C_HBITS-1:0] m_height,
   output logic               m_update,
   output logic               pending,
   output logic               clamped,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POS  = 2'd1,
      ST_SIZE = 2'd2
   } state_t;

   state_t r_state;

   // shadow window written by software
   logic [C_WBITS-1:0] r_sh_left, r_sh_width;
   logic [C_HBITS-1:0] r_sh_top, r_sh_height;
   logic               r_pending;

   // work copy of the request and image size, frozen at frame start
   logic [C_WBITS-1:0] r_wk_left, r_wk_width, r_img_w;
   logic [C_HBITS-1:0] r_wk_top, r_wk_height, r_img_h;

   // clamped position computed in ST_POS
   logic [C_WBITS-1:0] r_pos_left;
   logic [C_HBITS-1:0] r_pos_top;

   // published outputs
   logic [C_WBITS-1:0] r_m_left, r_m_width;
   logic [C_HBITS-1:0] r_m_top, r_m_height;
   logic               r_m_update, r_clamped;

   logic w_start;

   logic [C_WBITS-1:0] w_left_max, w_pos_left, w_avail_w, w_min_w, w_size_w;
   logic [C_HBITS-1:0] w_top_max, w_pos_top, w_avail_h, w_min_h, w_size_h;
   logic               w_clamp_any;

   // a frame start only matters when idle with something waiting
   assign w_start = (r_state == ST_IDLE) && fsync && r_pending;

   // position clamp: keep the origin inside the image (zero-size image -> 0)
   assign w_left_max = r_img_w - C_WBITS'(1);
   assign w_pos_left = (r_img_w == '0) ? '0 :
                       ((r_wk_left > w_left_max) ? w_left_max : r_wk_left);
   assign w_top_max  = r_img_h - C_HBITS'(1);
   assign w_pos_top  = (r_img_h == '0) ? '0 :
                       ((r_wk_top > w_top_max) ? w_top_max : r_wk_top);

   // size clamp: the clamped origin is inside the image, so the remaining
   // extent never underflows; a zero size is widened to one pixel
   assign w_avail_w = r_img_w - r_pos_left;
   assign w_min_w   = (r_wk_width < w_avail_w) ? r_wk_width : w_avail_w;
   assign w_size_w  = (r_img_w == '0) ? '0 :
                      ((w_min_w == '0) ? C_WBITS'(1) : w_min_w);
   assign w_avail_h = r_img_h - r_pos_top;
   assign w_min_h   = (r_wk_height < w_avail_h) ? r_wk_height : w_avail_h;
   assign w_size_h  = (r_img_h == '0) ? '0 :
                      ((w_min_h == '0) ? C_HBITS'(1) : w_min_h);

   assign w_clamp_any = (r_pos_left != r_wk_left)  || (w_size_w != r_wk_width) ||
                        (r_pos_top  != r_wk_top)   || (w_size_h != r_wk_height);

   // shadow registers and pending flag; a write in the same cycle as the
   // capturing frame start re-arms pending for the next frame
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sh_left   <= '0;
         r_sh_width  <= '0;
         r_sh_top    <= '0;
         r_sh_height <= '0;
         r_pending   <= 1'b0;
      end else begin
         if (s_wr_en) begin
            r_sh_left   <= s_left;
            r_sh_width  <= s_width;
            r_sh_top    <= s_top;
            r_sh_height <= s_height;
            r_pending   <= 1'b1;
         end else if (w_start) begin
            r_pending   <= 1'b0;
         end
      end
   end

   // capture -> position clamp -> size clamp and publish
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_wk_left   <= '0;
         r_wk_width  <= '0;
         r_wk_top    <= '0;
         r_wk_height <= '0;
         r_img_w     <= '0;
         r_img_h     <= '0;
         r_pos_left  <= '0;
         r_pos_top   <= '0;
         r_m_left    <= '0;
         r_m_width   <= '0;
         r_m_top     <= '0;
         r_m_height  <= '0;
         r_m_update  <= 1'b0;
         r_clamped   <= 1'b0;
      end else begin
         r_m_update <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_wk_left   <= r_sh_left;
                  r_wk_width  <= r_sh_width;
                  r_wk_top    <= r_sh_top;
                  r_wk_height <= r_sh_height;
                  r_img_w     <= img_width;
                  r_img_h     <= img_height;
                  r_state     <= ST_POS;
               end
            end
            ST_POS: begin
               r_pos_left <= w_pos_left;
               r_pos_top  <= w_pos_top;
               r_state    <= ST_SIZE;
            end
            ST_SIZE: begin
               r_m_left   <= r_pos_left;
               r_m_width  <= w_size_w;
               r_m_top    <= r_pos_top;
               r_m_height <= w_size_h;
               r_m_update <= 1'b1;
               r_clamped  <= w_clamp_any;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m_left    = r_m_left;
   assign m_width   = r_m_width;
   assign m_top     = r_m_top;
   assign m_height  = r_m_height;
   assign m_update  = r_m_update;
   assign pending   = r_pending;
   assign clamped   = r_clamped;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_window_updater.sv
// Bench for window_updater: drives writes / frame starts, predicts each
// published window and the edge it should appear on, and compares when the
// DUT pulses m_update.
module tb_window_updater;

   localparam int WB = 12;
   localparam int HB = 12;
   localparam int PW = 1 + 2*WB + 2*HB;   // {clamped, left, width, top, height}
   localparam int W  = 16 + PW;           // {publish cycle, window}

   logic          clk;
   logic          resetn;
   logic          s_wr_en;
   logic [WB-1:0] s_left, s_width, img_width;
   logic [HB-1:0] s_top, s_height, img_height;
   logic          fsync;
   logic [WB-1:0] m_left, m_width;
   logic [HB-1:0] m_top, m_height;
   logic          m_update, pending, clamped;
   logic [1:0]    dbg_state;

   window_updater #(.C_HBITS(HB), .C_WBITS(WB)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .s_wr_en    (s_wr_en),
      .s_left     (s_left),
      .s_width    (s_width),
      .s_top      (s_top),
      .s_height   (s_height),
      .img_width  (img_width),
      .img_height (img_height),
      .fsync      (fsync),
      .m_left     (m_left),
      .m_width    (m_width),
      .m_top      (m_top),
      .m_height   (m_height),
      .m_update   (m_update),
      .pending    (pending),
      .clamped    (clamped),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int n_pub  = 0;
   int n_upd  = 0;

   // model of the shadow and last published window
   int sh_l, sh_w, sh_t, sh_h;
   bit sh_pend;
   int last_l;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference clamp, written straight from the window rules
   function automatic logic [PW-1:0] model(input int l, input int w, input int t,
                                           input int h, input int iw, input int ih);
      int lo, wo, to, ho;
      bit c;
      if (iw == 0) begin
         lo = 0; wo = 0;
      end else begin
         lo = (l >= iw) ? iw - 1 : l;
         wo = (w < iw - lo) ? w : iw - lo;
         if (wo == 0) wo = 1;
      end
      if (ih == 0) begin
         to = 0; ho = 0;
      end else begin
         to = (t >= ih) ? ih - 1 : t;
         ho = (h < ih - to) ? h : ih - to;
         if (ho == 0) ho = 1;
      end
      c = (lo != l) || (wo != w) || (to != t) || (ho != h);
      return {c, WB'(lo), WB'(wo), HB'(to), HB'(ho)};
   endfunction

   // called at the negedge where fsync is driven: capture edge is cyc+1,
   // publish edge is cyc+3
   task automatic push_expected();
      logic [PW-1:0] e;
      e = model(sh_l, sh_w, sh_t, sh_h, int'(img_width), int'(img_height));
      exp_q.push_back({16'(cyc + 3), e});
      last_l = int'(e[2*HB+2*WB-1 -: WB]);
      n_pub++;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (resetn && m_update) begin
         n_upd++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_update", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("publish_cycle", 32'(cyc[15:0]), 32'(e[W-1 -: 16]));
            check_eq("m_clamped", 32'(clamped),  32'(e[PW-1]));
            check_eq("m_left",    32'(m_left),   32'(e[2*HB+2*WB-1 -: WB]));
            check_eq("m_width",   32'(m_width),  32'(e[2*HB+WB-1 -: WB]));
            check_eq("m_top",     32'(m_top),    32'(e[2*HB-1 -: HB]));
            check_eq("m_height",  32'(m_height), 32'(e[HB-1 -: HB]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_write(input int l, input int w, input int t, input int h,
                              input bit with_fsync);
      @(negedge clk);
      s_wr_en = 1'b1;
      s_left = WB'(l); s_width = WB'(w); s_top = HB'(t); s_height = HB'(h);
      if (with_fsync) begin
         fsync = 1'b1;
         if (sh_pend) push_expected();
      end
      sh_l = l; sh_w = w; sh_t = t; sh_h = h; sh_pend = 1'b1;
      @(negedge clk);
      s_wr_en = 1'b0;
      fsync   = 1'b0;
   endtask

   task automatic drive_fsync();
      @(negedge clk);
      fsync = 1'b1;
      if (sh_pend) push_expected();
      sh_pend = 1'b0;
      @(negedge clk);
      fsync = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      resetn = 1'b0; s_wr_en = 1'b0; fsync = 1'b0;
      s_left = '0; s_width = '0; s_top = '0; s_height = '0;
      img_width = 12'd1920; img_height = 12'd1080;
      sh_l = 0; sh_w = 0; sh_t = 0; sh_h = 0; sh_pend = 1'b0; last_l = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_m_left",   32'(m_left),   32'd0);
      check_eq("rst_m_height", 32'(m_height), 32'd0);
      check_eq("rst_m_update", 32'(m_update), 32'd0);
      check_eq("rst_pending",  32'(pending),  32'd0);
      check_eq("rst_clamped",  32'(clamped),  32'd0);
      resetn = 1'b1;

      // basic publish
      drive_write(100, 200, 50, 60, 1'b0);
      check_eq("basic_pending_set", 32'(pending), 32'd1);
      drive_fsync();
      check_eq("basic_pending_clr", 32'(pending), 32'd0);
      settle();

      // size clamp, then position clamp
      drive_write(1800, 400, 1000, 200, 1'b0);
      drive_fsync();
      settle();
      drive_write(4000, 10, 2000, 5, 1'b0);
      drive_fsync();
      settle();

      // collision: A pending, B written with fsync -> A now, B next frame
      drive_write(10, 20, 30, 40, 1'b0);
      drive_write(11, 21, 31, 41, 1'b1);
      check_eq("coll_pending_kept", 32'(pending), 32'd1);
      settle();
      drive_fsync();
      settle();

      // frame start with nothing pending is ignored
      drive_fsync();
      settle();
      check_eq("idle_fsync_hold", 32'(m_left), 32'(last_l));

      // write + fsync with nothing pending: fsync ignored, write stays pending
      drive_write(7, 8, 9, 10, 1'b1);
      settle();
      check_eq("coll_idle_pending", 32'(pending), 32'd1);
      drive_fsync();
      settle();

      // busy: repeated fsync in POS ignored, write during SIZE held
      drive_write(500, 600, 300, 400, 1'b0);
      @(negedge clk);
      fsync = 1'b1;
      push_expected();
      sh_pend = 1'b0;
      @(negedge clk);                    // fsync still high, sampled in POS
      @(negedge clk);                    // write sampled in SIZE
      fsync = 1'b0;
      s_wr_en = 1'b1;
      s_left = 12'd1; s_width = 12'd2; s_top = 12'd3; s_height = 12'd4;
      sh_l = 1; sh_w = 2; sh_t = 3; sh_h = 4; sh_pend = 1'b1;
      @(negedge clk);
      s_wr_en = 1'b0;
      check_eq("busy_pending", 32'(pending), 32'd1);
      settle();
      drive_fsync();
      settle();

      // zero-size image collapses the window
      img_width = '0; img_height = '0;
      drive_write(5, 5, 5, 5, 1'b0);
      drive_fsync();
      settle();
      img_width = 12'd1920; img_height = 12'd1080;

      // reset while in POS aborts the publish
      drive_write(900, 100, 900, 100, 1'b0);
      @(negedge clk);
      fsync = 1'b1;
      sh_pend = 1'b0;
      @(negedge clk);                    // FSM now in POS
      fsync = 1'b0;
      #1 resetn = 1'b0;
      #1;
      check_eq("abort_m_left",   32'(m_left),   32'd0);
      check_eq("abort_m_width",  32'(m_width),  32'd0);
      check_eq("abort_m_top",    32'(m_top),    32'd0);
      check_eq("abort_m_update", 32'(m_update), 32'd0);
      check_eq("abort_pending",  32'(pending),  32'd0);
      check_eq("abort_clamped",  32'(clamped),  32'd0);
      sh_l = 0; sh_w = 0; sh_t = 0; sh_h = 0;
      @(negedge clk);
      resetn = 1'b1;
      drive_fsync();
      settle();
      check_eq("post_rst_m_left", 32'(m_left), 32'd0);

      check_eq("updates_seen", 32'(n_upd), 32'(n_pub));
      check_eq("queue_empty",  32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/window_updater.md
# window_updater

Frame-synchronous source of the crop window for the video window path. Software-side writes land in shadow registers. At the next frame-start pulse the window is clamped to the current image size and published on `m_*`. The `m_*` outputs feed the window broadcaster's `s_*` inputs directly, so every consumer sees one coherent window that changes only between frames.

## Interface
Parameters:
- `C_HBITS`, 12, bit width of vertical quantities (top, height, image height)
- `C_WBITS`, 12, bit width of horizontal quantities (left, width, image width)

Ports:
- `clk`  in  1  single clock for all logic
- `resetn`  in  1  reset, asynchronous assert, active-low
- `s_wr_en`  in  1  one-cycle strobe; latch `s_left`/`s_width`/`s_top`/`s_height` into shadow
- `s_left`  in  C_WBITS  requested left edge
- `s_width`  in  C_WBITS  requested width
- `s_top`  in  C_HBITS  requested top edge
- `s_height`  in  C_HBITS  requested height
- `img_width`  in  C_WBITS  current image width, quasi-static
- `img_height`  in  C_HBITS  current image height, quasi-static
- `fsync`  in  1  one-cycle frame-start pulse
- `m_left`, `m_width`  out  C_WBITS  published window, horizontal
- `m_top`, `m_height`  out  C_HBITS  published window, vertical
- `m_update`  out  1  one-cycle pulse in the cycle new `m_*` values first appear
- `pending`  out  1  shadow holds a window not yet published
- `clamped`  out  1  last published window was modified by clamping

## Operation
- Shadow regs `sh_*`:
  - Loaded on `s_wr_en`; `pending` is set.
  - Further writes overwrite the shadow (last write wins).
- FSM states:
  - IDLE:
    - `fsync` with `pending` = 1: capture `sh_*`, `img_width`, `img_height` into work regs; clear `pending` (unless `s_wr_en` is high the same cycle, see below); go to POS.
    - `fsync` with `pending` = 0: ignored.
  - POS: compute the clamped position; go to SIZE.
    - `left'` = (`img_width` = 0) ? 0 : min(`left`, `img_width` − 1).
    - `top'` likewise, using `img_height`.
  - SIZE: compute the clamped size; go to IDLE.
    - `width'` = min(`width`, `img_width` − `left'`).
    - If `width'` = 0 and `img_width` ≠ 0, force `width'` to 1. If `img_width` = 0, `width'` = 0.
    - `height'` likewise, using `img_height`.
    - Register all four `m_*` together, assert `m_update`, and set `clamped` if any field differs from the captured request.
- Arithmetic: subtractions are unsigned at parameter width; operands are guaranteed non-negative by the position clamp. No wider intermediates are needed.
- `s_wr_en` and `fsync` in the same IDLE cycle:
  - The capture takes the pre-write shadow.
  - The new write sets `pending` again, so it publishes at the next frame.
  - If `pending` was 0 before that cycle, the `fsync` is ignored and the write stays pending.
- `s_wr_en` during POS/SIZE: updates the shadow and sets `pending`; the in-flight computation is unaffected.
- `fsync` during POS/SIZE: ignored; no queuing.
- `img_*` changes after capture have no effect until the next `fsync`.

## Timing
- `fsync` sampled at edge k → POS at k+1 → `m_*` and `m_update` registered at edge k+2. Latency is 2 cycles.
- `m_update` is high for exactly one cycle (k+2 to k+3). `m_*` hold until the next publish.
- `clamped` updates at the same edge as `m_*`.
- `pending` clears at edge k, unless a simultaneous write sets it.
- Reset (async, `resetn` = 0): all `m_*` = 0, `m_update` = 0, `pending` = 0, `clamped` = 0, `sh_*` = 0, FSM = IDLE.
- Reset mid-operation (POS/SIZE) aborts the computation; nothing is published.
- Release is synchronous to `clk`. The first `s_wr_en` is accepted on the first edge after release.

## Test plan
- Basic publish: reset; `img` = 1920×1080; write (100, 200, 50, 60); `fsync` at edge k → `m_*` = (100, 200, 50, 60) at edge k+2; `m_update` pulses once; `clamped` = 0; `pending` 1→0.
- Clamp size: `img` = 1920×1080; write left = 1800, width = 400, top = 1000, height = 200; `fsync` → `m_width` = 120, `m_height` = 80, `clamped` = 1.
- Clamp position: write left = 4000, width = 10, top = 2000, height = 5; `img` = 1920×1080 → `m_left` = 1919, `m_width` = 1, `m_top` = 1079, `m_height` = 1, `clamped` = 1.
- Collision:
  - Pending A; write B coincident with `fsync` → A published at +2, `pending` = 1; next `fsync` publishes B.
  - `fsync` with nothing pending → no `m_update`, `m_*` unchanged.
- Busy: second `fsync` in POS ignored, single `m_update`. A write during SIZE is held and published at the following `fsync`.
- Reset: assert `resetn` = 0 in POS → all outputs 0 immediately. After release, `fsync` alone produces no `m_update`.
